// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, starvation default and source encoding for the
// register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned ADDR_W_DEF     = 4;
  localparam int unsigned STARVE_LIM_DEF = 3;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_M = 1'b1
  } src_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback hold buffer: flush beats load, load beats clear so a
// granted slot can be refilled on the same edge.
module wb_hold_slot #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load
// writeback, and flags read-after-write hazards on the two read ports.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF,
  parameter bit          DROP_R0    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              haz1,
  output logic              haz2,
  output logic              idle
);

  logic              a_full, m_full, a_load, m_load, a_grant, m_grant, any_grant;
  logic [ADDR_W-1:0] a_haddr, m_haddr;
  logic [DATA_W-1:0] a_hdata, m_hdata;
  logic [2:0]        starve;
  logic              m_older;
  src_e              winner;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_a_slot (
    .clk(clk), .rst_n(rst_n), .flush(flush), .load(a_load), .clear(a_grant),
    .load_addr(a_addr), .load_data(a_data),
    .full(a_full), .addr(a_haddr), .data(a_hdata)
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_m_slot (
    .clk(clk), .rst_n(rst_n), .flush(flush), .load(m_load), .clear(m_grant),
    .load_addr(m_addr), .load_data(m_data),
    .full(m_full), .addr(m_haddr), .data(m_hdata)
  );

  // Flushed entries never reach the port, so no grant is issued in a flush cycle.
  always_comb begin
    winner    = SRC_A;
    any_grant = 1'b0;
    if (!flush) begin
      if (a_full && m_full) begin
        any_grant = 1'b1;
        if (a_haddr == m_haddr)
          winner = m_older ? SRC_M : SRC_A;
        else if (starve >= 3'(STARVE_LIM))
          winner = SRC_M;
      end else if (a_full) begin
        any_grant = 1'b1;
      end else if (m_full) begin
        any_grant = 1'b1;
        winner    = SRC_M;
      end
    end
  end

  assign a_grant = any_grant && (winner == SRC_A);
  assign m_grant = any_grant && (winner == SRC_M);
  assign a_ready = !a_full || a_grant;
  assign m_ready = !m_full || m_grant;
  assign a_load  = a_valid && a_ready && !flush && !(DROP_R0 && (a_addr == '0));
  assign m_load  = m_valid && m_ready && !flush && !(DROP_R0 && (m_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve   <= '0;
      m_older  <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (flush || !m_full || m_grant)
        starve <= '0;
      else if (starve != 3'd7)
        starve <= starve + 3'd1;
      // Age only matters while both slots hold entries; a same-edge double load counts A as older.
      if (a_load && !m_load && m_full && !m_grant)
        m_older <= 1'b1;
      else if (m_load && (a_load || (a_full && !a_grant)))
        m_older <= 1'b0;
      rf_we <= any_grant;
      if (any_grant) begin
        rf_waddr <= (winner == SRC_M) ? m_haddr : a_haddr;
        rf_wdata <= (winner == SRC_M) ? m_hdata : a_hdata;
      end
    end
  end

  function automatic logic pending_match(input logic [ADDR_W-1:0] rd);
    pending_match = !(DROP_R0 && (rd == '0)) &&
                    ((a_full && (a_haddr == rd)) || (m_full && (m_haddr == rd)) ||
                     (rf_we && (rf_waddr == rd)));
  endfunction

  assign haz1 = pending_match(rd_addr1);
  assign haz2 = pending_match(rd_addr2);
  assign idle = !a_full && !m_full && !rf_we;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written
// starvation/flush/reset sequences, and a randomized run against a
// timestamp-based reference model.
module tb_regfile_wb_arbiter;

  localparam int LIM = 3;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        a_valid = 1'b0, m_valid = 1'b0;
  logic [3:0]  a_addr = '0, m_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [15:0] a_data = '0, m_data = '0;
  logic        a_ready, m_ready, rf_we, haz1, haz2, idle;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;

  int checks = 0, errors = 0;

  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .STARVE_LIM(LIM), .DROP_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .haz1(haz1), .haz2(haz2), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av; logic [3:0] aa; logic [15:0] ad;
    logic        mv; logic [3:0] ma; logic [15:0] md;
    logic        fl; logic [3:0] r1; logic [3:0] r2;
    logic        e_ar, e_mr, e_we; logic [3:0] e_wa; logic [15:0] e_wd;
    logic        e_h1, e_h2, e_idle;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    m_valid = v.mv; m_addr = v.ma; m_data = v.md;
    flush = v.fl; rd_addr1 = v.r1; rd_addr2 = v.r2;
  endtask

  task automatic clear_inputs();
    a_valid = 0; m_valid = 0; flush = 0; a_addr = 0; m_addr = 0;
    a_data = 0; m_data = 0; rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: pending entries carry the cycle they were accepted in.
  bit          ma_full, mm_full, mdl_we;
  logic [3:0]  ma_addr, mm_addr, mdl_waddr;
  logic [15:0] ma_data, mm_data, mdl_wdata;
  int          ma_ts, mm_ts, mdl_lost, cyc;

  task automatic model_reset();
    ma_full = 0; mm_full = 0; mdl_we = 0; mdl_waddr = 0; mdl_wdata = 0;
    mdl_lost = 0; cyc = 0;
  endtask

  task automatic model_grant(output bit ga, output bit gm);
    ga = 0; gm = 0;
    if (!flush) begin
      if (ma_full && mm_full) begin
        if (ma_addr == mm_addr) begin
          ga = (ma_ts <= mm_ts); gm = !ga;
        end else begin
          gm = (mdl_lost >= LIM); ga = !gm;
        end
      end else begin
        ga = ma_full; gm = mm_full;
      end
    end
  endtask

  function automatic bit model_haz(input logic [3:0] rd);
    if (rd == 0) return 0;
    return (ma_full && ma_addr == rd) || (mm_full && mm_addr == rd) || (mdl_we && mdl_waddr == rd);
  endfunction

  task automatic model_compare();
    bit ga, gm;
    model_grant(ga, gm);
    chk("rnd_a_ready", a_ready, !ma_full || ga);
    chk("rnd_m_ready", m_ready, !mm_full || gm);
    chk("rnd_rf_we", rf_we, mdl_we);
    chk("rnd_rf_waddr", rf_waddr, mdl_waddr);
    chk("rnd_rf_wdata", rf_wdata, mdl_wdata);
    chk("rnd_haz1", haz1, model_haz(rd_addr1));
    chk("rnd_haz2", haz2, model_haz(rd_addr2));
    chk("rnd_idle", idle, !ma_full && !mm_full && !mdl_we);
  endtask

  task automatic model_step();
    bit ga, gm, acc_a, acc_m;
    model_grant(ga, gm);
    acc_a = a_valid && (!ma_full || ga) && !flush && a_addr != 0;
    acc_m = m_valid && (!mm_full || gm) && !flush && m_addr != 0;
    mdl_we = ga || gm;
    if (ga) begin mdl_waddr = ma_addr; mdl_wdata = ma_data; end
    if (gm) begin mdl_waddr = mm_addr; mdl_wdata = mm_data; end
    if (flush || !mm_full || gm) mdl_lost = 0;
    else if (mdl_lost < 7) mdl_lost++;
    if (flush) begin ma_full = 0; mm_full = 0; end
    else begin
      if (acc_a) begin ma_full = 1; ma_addr = a_addr; ma_data = a_data; ma_ts = cyc; end
      else if (ga) ma_full = 0;
      if (acc_m) begin mm_full = 1; mm_addr = m_addr; mm_data = m_data; mm_ts = cyc; end
      else if (gm) mm_full = 0;
    end
    cyc++;
  endtask

  vec_t vecs[$];

  initial begin
    // av aa ad      mv ma md       fl r1 r2 | ar mr we wa wd       h1 h2 idle
    vecs.push_back('{1, 2, 16'd69,   0, 0, 0,       0, 2, 0,  1, 1, 0, 0, 0,        0, 0, 1});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 2, 0,  1, 1, 0, 0, 0,        1, 0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 2, 0,  1, 1, 1, 2, 16'd69,   1, 0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 2, 0,  1, 1, 0, 2, 16'd69,   0, 0, 1});
    vecs.push_back('{0, 0, 0,        1, 4, 16'h0011,0, 4, 0,  1, 1, 0, 2, 16'd69,   0, 0, 1});
    vecs.push_back('{1, 4, 16'h0022, 0, 0, 0,       0, 4, 0,  1, 1, 0, 2, 16'd69,   1, 0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 4, 0,  1, 1, 1, 4, 16'h0011, 1, 0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 4, 0,  1, 1, 1, 4, 16'h0022, 1, 0, 0});
    vecs.push_back('{1, 0, 16'hFFFF, 0, 0, 0,       0, 0, 0,  1, 1, 0, 4, 16'h0022, 0, 0, 1});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 0, 0,  1, 1, 0, 4, 16'h0022, 0, 0, 1});
    vecs.push_back('{0, 0, 0,        1, 6, 16'h0ABC,0, 6, 0,  1, 1, 0, 4, 16'h0022, 0, 0, 1});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 6, 0,  1, 1, 0, 4, 16'h0022, 1, 0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 6, 0,  1, 1, 1, 6, 16'h0ABC, 1, 0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,       0, 6, 0,  1, 1, 0, 6, 16'h0ABC, 0, 0, 1});

    // Reset state
    #2;
    chk("rst_rf_we", rf_we, 0); chk("rst_rf_waddr", rf_waddr, 0); chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_a_ready", a_ready, 1); chk("rst_m_ready", m_ready, 1);
    chk("rst_haz1", haz1, 0); chk("rst_haz2", haz2, 0); chk("rst_idle", idle, 1);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_a_ready", i), a_ready, vecs[i].e_ar);
      chk($sformatf("vec%0d_m_ready", i), m_ready, vecs[i].e_mr);
      chk($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].e_we);
      chk($sformatf("vec%0d_rf_waddr", i), rf_waddr, vecs[i].e_wa);
      chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].e_wd);
      chk($sformatf("vec%0d_haz1", i), haz1, vecs[i].e_h1);
      chk($sformatf("vec%0d_haz2", i), haz2, vecs[i].e_h2);
      chk($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
    end

    // Starvation: both sources stream; A gets LIM grants, then M one.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_valid = 1; a_addr = 3; a_data = 16'(100 + i);
      m_valid = 1; m_addr = 5; m_data = 16'(200 + i);
      #1;
      chk($sformatf("starve%0d_m_ready", i), m_ready, (i == 0) || (i % (LIM + 1) == 0));
      chk($sformatf("starve%0d_a_ready", i), a_ready, (i == 0) || (i % (LIM + 1) != 0));
      if (i >= 2) begin
        chk($sformatf("starve%0d_rf_we", i), rf_we, 1);
        chk($sformatf("starve%0d_rf_waddr", i), rf_waddr, ((i - 1) % (LIM + 1) == 0) ? 5 : 3);
      end
    end

    // Flush with both holds full: in-flight write finishes, nothing else follows.
    do_reset();
    @(negedge clk); a_valid = 1; a_addr = 7; a_data = 16'h0707; m_valid = 1; m_addr = 9; m_data = 16'h0909;
    @(negedge clk); clear_inputs();
    @(negedge clk); flush = 1; #1;
    chk("flush_inflight_we", rf_we, 1); chk("flush_inflight_waddr", rf_waddr, 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); flush = 0; #1;
      chk($sformatf("flush_after%0d_rf_we", i), rf_we, 0);
      chk($sformatf("flush_after%0d_idle", i), idle, 1);
    end

    // Async reset while a write is on the port.
    @(negedge clk); a_valid = 1; a_addr = 1; a_data = 16'h0005;
    @(negedge clk); clear_inputs();
    @(negedge clk); #1;
    chk("rstmid_pre_we", rf_we, 1);
    rst_n = 1'b0; #1;
    chk("rstmid_we_drop", rf_we, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rstmid_idle", idle, 1); chk("rstmid_waddr", rf_waddr, 0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      a_valid = ($urandom_range(0, 99) < 60); a_addr = 4'($urandom_range(0, 5)); a_data = 16'($urandom);
      m_valid = ($urandom_range(0, 99) < 60); m_addr = 4'($urandom_range(0, 5)); m_data = 16'($urandom);
      flush = ($urandom_range(0, 99) < 5);
      rd_addr1 = 4'($urandom_range(0, 7)); rd_addr2 = 4'($urandom_range(0, 7));
      #1;
      model_compare();
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register_file write port (regWrite / wrReg_addr / wr_data) between two writeback sources: ALU result (A) and memory load result (M).
- Each source has a valid/ready handshake and a one-entry hold buffer. A fixed-priority arbiter with a starvation guard drives registered write-port outputs.
- Also reports read-after-write hazards on the two register-file read addresses, so the control unit can stall.

Parameters:
DATA_W, 16, data width (matches register_file)
ADDR_W, 4, register address width (16 registers)
STARVE_LIM, 3, consecutive lost cycles after which M takes priority; legal range 1..7
DROP_R0, 1, when 1, accepted writes to address 0 are discarded (never reach the port)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  sync clear of both hold buffers (output stage unaffected)
a_valid  in  1  ALU writeback request
a_addr  in  ADDR_W  ALU destination register
a_data  in  DATA_W  ALU result
a_ready  out  1  ALU request accepted this cycle when a_valid&a_ready
m_valid  in  1  load writeback request
m_addr  in  ADDR_W  load destination register
m_data  in  DATA_W  load data
m_ready  out  1  load handshake ready
rf_we  out  1  to register_file regWrite
rf_waddr  out  ADDR_W  to wrReg_addr
rf_wdata  out  DATA_W  to wr_data
rd_addr1  in  ADDR_W  register_file read address 1 (monitored)
rd_addr2  in  ADDR_W  register_file read address 2 (monitored)
haz1  out  1  rd_addr1 matches a pending write
haz2  out  1  rd_addr2 matches a pending write
idle  out  1  both holds empty and rf_we low

Behaviour:
- Reset (async, rst_n=0):
  - Both holds empty; rf_we=0, rf_waddr=0, rf_wdata=0.
  - Starvation counter=0; age bit cleared.
  - a_ready=m_ready=1, haz1=haz2=0, idle=1.
- Reset asserted mid-operation: pending hold contents are lost and rf_we drops immediately.
- Hold buffer per source, fields {full, addr, data}:
  - Loaded on the edge where valid&ready.
  - Cleared on the edge where it wins the grant.
  - ready = !full | grant_this_cycle (combinational). This gives 1 write/cycle throughput for the winning source.
- Arbitration (combinational, among full holds):
  - Only one full: it wins.
  - Both full, different addr: A wins, unless starve count >= STARVE_LIM, in which case M wins.
  - Both full, same addr: the older entry wins regardless of priority. If both were accepted on the same edge, A is older.
- Output stage (registered):
  - On the edge after a grant: rf_we=1 and rf_waddr/rf_wdata take the winner's fields.
  - With no grant: rf_we=0 and addr/data hold their last values.
  - Latency from accept edge to rf_we high is 1 cycle (the grant is evaluated on the following edge).
- Starvation counter (3 bits, saturating):
  - Increments each cycle M is full and not granted.
  - Clears on an M grant, and when M is empty.
- Age bit: set when one hold is loaded while the other is already full; records which entry is older.
- DROP_R0=1 and addr=0: the handshake completes normally but the hold is not loaded; no rf_we pulse results.
- flush:
  - Clears both holds and the starve counter on that edge.
  - A valid handshake in the flush cycle is discarded.
  - The output stage still completes its pending write.
  - flush takes precedence over a simultaneous load.
- Hazards: hazN=1 when rd_addrN equals the addr of a full hold, or equals rf_waddr while rf_we=1.
  - Purely combinational.
  - Address 0 never flags when DROP_R0=1.
- idle = !a_full & !m_full & !rf_we.

Decomposition:
- Shared package/header holds: DATA_W/ADDR_W defaults (shared with register_file), STARVE_LIM default, and source encoding constants SRC_A=0, SRC_M=1.
- One natural sub-module: wb_hold_slot, the one-entry valid/ready hold buffer (full/addr/data, load/clear/flush), instantiated once per source.
- Arbitration, starve counter, output stage and hazard compare stay in the top module.

Test Plan:
- Reset then single A write: a_valid=1, a_addr=2, a_data=69 for one cycle -> rf_we=1, rf_waddr=2, rf_wdata=69 exactly one cycle later, for one cycle; idle returns to 1.
- Both sources valid every cycle (A addr 3, M addr 5) with STARVE_LIM=3 -> A holds the port for 3 grants, then M is written, and the pattern repeats; m_ready stays low while M is blocked.
- Same address collision: M accepted at cycle 0 (addr 4, data 0x0011), A at cycle 1 (addr 4, data 0x0022) -> port writes 0x0011 then 0x0022 to address 4.
- DROP_R0: a_valid with addr 0, data 0xFFFF -> a_ready=1, no rf_we pulse, haz1=0 when rd_addr1=0.
- Hazard: M hold full with addr 6 while rd_addr1=6, rd_addr2=0 -> haz1=1, haz2=0; after the write completes, both are 0.
- Flush and reset mid-operation:
  - Both holds full, flush=1 -> no further rf_we after the in-flight write.
  - rst_n low while rf_we=1 -> rf_we=0 immediately, and idle=1 once reset is released.
